pattern_scan_ctrl: RTL and testbench

//  Frame sequencer for the serial pattern-detection datapath. Accepts a scan request
//  (pattern + frame length in bits), pulls bytes over a valid/ready handshake and

---
 rtl/pattern_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Frame sequencer: fetches bytes over valid/ready, serialises them MSB-first and
// counts overlapping occurrences of a PAT_W-bit pattern with a Mealy matcher.
module pattern_scan_ctrl #(
  parameter int PAT_W  = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [PAT_W-1:0]  cfg_pat_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  input  logic [DATA_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              match_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-2:0]  r_hist;
  logic [LEN_W-1:0]  r_remain;
  logic [LEN_W-1:0]  r_bitsSeen;
  logic [DATA_W-1:0] r_byte;
  logic [IDX_W-1:0]  r_bitIdx;
  logic [CNT_W-1:0]  r_count;
  logic              r_busy;
  logic              r_ready;
  logic              r_done;

  logic              w_bit;
  logic [PAT_W-1:0]  w_window;
  logic              w_match;

  // The window is the last PAT_W-1 bits plus the bit being shifted this cycle.
  assign w_bit    = r_byte[r_bitIdx];
  assign w_window = {r_hist, w_bit};
  assign w_match  = (r_state == S_SHIFT) && (w_window == r_pat) &&
                    (r_bitsSeen >= LEN_W'(PAT_W - 1));

  assign busy_o       = r_busy;
  assign byte_ready_o = r_ready;
  assign done_o       = r_done;
  assign match_o      = w_match;
  assign count_o      = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pat      <= '0;
      r_hist     <= '0;
      r_remain   <= '0;
      r_bitsSeen <= '0;
      r_byte     <= '0;
      r_bitIdx   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_pat      <= cfg_pat_i;
            r_remain   <= len_i;
            r_count    <= '0;
            r_hist     <= '0;
            r_bitsSeen <= '0;
            r_busy     <= 1'b1;
            if (len_i != '0) begin
              r_state <= S_LOAD;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (byte_valid_i) begin
            r_byte   <= byte_i;
            r_bitIdx <= IDX_W'(DATA_W - 1);
            r_ready  <= 1'b0;
            r_state  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_hist     <= w_window[PAT_W-2:0];
          r_bitsSeen <= r_bitsSeen + LEN_W'(1);
          r_remain   <= r_remain - LEN_W'(1);
          if (w_match && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
          end
          // Frame end wins over byte end: leftover low bits of the last byte are dropped.
          if (r_remain == LEN_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_bitIdx == '0) begin
            r_state <= S_LOAD;
            r_ready <= 1'b1;
          end else begin
            r_bitIdx <= r_bitIdx - IDX_W'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed frames plus a long random stream, all
// checked against a bit-list reference model of the overlapping match rule.
module tb_pattern_scan_ctrl;

  localparam int PAT_W  = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [PAT_W-1:0]  cfg_pat_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic [DATA_W-1:0] byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              match_o;
  logic              done_o;
  logic [CNT_W-1:0]  count_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [DATA_W-1:0] frameBytes[$];
  bit                expMatch[$];
  bit                obsMatch[$];
  int                obsStray, obsReadyShift, obsBusyLow, obsFetched;
  bit                obsTimeout, obsEarlyDone, obsDone, obsIdleBusy;
  logic [CNT_W-1:0]  obsCount;

  pattern_scan_ctrl #(
    .PAT_W (PAT_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .cfg_pat_i   (cfg_pat_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .match_o     (match_o),
    .done_o      (done_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flatten the frame to a bit list, then test every PAT_W-bit slice.
  function automatic int model_frame(input logic [PAT_W-1:0] pat, input int len);
    bit bits[$];
    bit hit;
    int cnt = 0;
    expMatch.delete();
    foreach (frameBytes[i])
      for (int b = DATA_W - 1; b >= 0; b--) bits.push_back(frameBytes[i][b]);
    for (int k = 0; k < len; k++) begin
      hit = (k >= PAT_W - 1);
      for (int j = 0; j < PAT_W && hit; j++)
        if (bits[k - PAT_W + 1 + j] != pat[PAT_W - 1 - j]) hit = 1'b0;
      expMatch.push_back(hit);
      if (hit && cnt < (1 << CNT_W) - 1) cnt++;
    end
    return cnt;
  endfunction

  // Drives one frame and records what the DUT did; judging is left to each test.
  task automatic run_frame(input logic [PAT_W-1:0] pat, input int len, input int maxStall,
                           input bit fixedStall, input bit pokeStart);
    int shiftLeft, bitsIssued, bitsShifted, stall, cyc, budget;
    obsMatch.delete();
    obsStray = 0; obsReadyShift = 0; obsBusyLow = 0; obsFetched = 0;
    obsTimeout = 1'b1; obsEarlyDone = 1'b0; obsDone = 1'b0; obsCount = '0;
    @(negedge clk);
    start_i = 1'b1; cfg_pat_i = pat; len_i = LEN_W'(len);
    @(negedge clk);
    start_i = 1'b0; cfg_pat_i = PAT_W'($urandom); len_i = LEN_W'($urandom);
    shiftLeft = 0; bitsIssued = 0; bitsShifted = 0; cyc = 0;
    stall  = fixedStall ? maxStall : int'($urandom_range(maxStall, 0));
    budget = (len / DATA_W + 2) * (DATA_W + 1 + maxStall) + 20;
    while (cyc < budget) begin
      if (pokeStart && cyc == 0) begin
        start_i = 1'b1; cfg_pat_i = ~pat; len_i = LEN_W'(3);
      end else begin
        start_i = 1'b0;
      end
      if (!busy_o) obsBusyLow++;
      byte_valid_i = 1'b0;
      if (shiftLeft > 0) begin
        obsMatch.push_back(match_o);
        if (byte_ready_o) obsReadyShift++;
        if (done_o) begin obsEarlyDone = 1'b1; obsTimeout = 1'b0; break; end
        shiftLeft--; bitsShifted++;
      end else begin
        if (match_o) obsStray++;
        if (bitsShifted == len) begin
          obsDone = done_o; obsCount = count_o; obsTimeout = 1'b0;
          break;
        end
        if (done_o) begin obsEarlyDone = 1'b1; obsTimeout = 1'b0; break; end
        if (byte_ready_o) begin
          if (stall > 0) begin
            stall--;
          end else begin
            byte_valid_i = 1'b1;
            byte_i = (obsFetched < frameBytes.size()) ? frameBytes[obsFetched] : DATA_W'($urandom);
            obsFetched++;
            shiftLeft = (len - bitsIssued < DATA_W) ? len - bitsIssued : DATA_W;
            bitsIssued += shiftLeft;
            stall = fixedStall ? maxStall : int'($urandom_range(maxStall, 0));
          end
        end
      end
      cyc++;
      @(negedge clk);
    end
    @(negedge clk);
    start_i = 1'b0; byte_valid_i = 1'b0;
    obsIdleBusy = busy_o;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = '0;
    cfg_pat_i = '0; len_i = '0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: busy=%b ready=%b expected 0/0", busy_o, byte_ready_o);
    end
    testsRun++;
    if (match_o !== 1'b0 || done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pulses: match=%b done=%b expected 0/0", match_o, done_o);
    end
    testsRun++;
    if (count_o !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_count: got %0d expected 0", count_o);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: busy=%b expected 0", busy_o);
    end
  endtask

  typedef struct {
    logic [PAT_W-1:0]  pat;
    int                len;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
    int                specCnt;
    int                stall;
    bit                poke;
  } vec_t;

  // Directed frames with their known counts; the last one holds valid low 10 cycles.
  task automatic test_directed();
    vec_t vecs[7];
    int   exp;
    int   nb;
    vecs[0] = '{4'b1011, 8,  8'hB6, 8'h00, 2, 0,  1'b0};
    vecs[1] = '{4'b1111, 8,  8'hFF, 8'h00, 5, 0,  1'b0};
    vecs[2] = '{4'b1011, 16, 8'h05, 8'h80, 1, 0,  1'b0};
    vecs[3] = '{4'b1011, 5,  8'hB6, 8'h00, 1, 0,  1'b0};
    vecs[4] = '{4'b1011, 0,  8'h00, 8'h00, 0, 0,  1'b1};
    vecs[5] = '{4'b1111, 8,  8'hFF, 8'h00, 5, 0,  1'b1};
    vecs[6] = '{4'b1011, 16, 8'h05, 8'h80, 1, 10, 1'b0};
    for (int v = 0; v < 7; v++) begin
      frameBytes = {vecs[v].b0, vecs[v].b1};
      exp = model_frame(vecs[v].pat, vecs[v].len);
      nb  = (vecs[v].len + DATA_W - 1) / DATA_W;
      run_frame(vecs[v].pat, vecs[v].len, vecs[v].stall, 1'b1, vecs[v].poke);
      testsRun++;
      if (obsTimeout || obsEarlyDone || !obsDone) begin
        testsFailed++;
        $display("[TB] FAIL dir%0d_done: timeout=%b early=%b done=%b expected 0/0/1",
                 v, obsTimeout, obsEarlyDone, obsDone);
      end
      testsRun++;
      if (obsCount !== CNT_W'(vecs[v].specCnt) || exp != vecs[v].specCnt) begin
        testsFailed++;
        $display("[TB] FAIL dir%0d_count: got %0d model %0d expected %0d",
                 v, obsCount, exp, vecs[v].specCnt);
      end
      for (int i = 0; i < vecs[v].len; i++) begin
        testsRun++;
        if (obsMatch.size() <= i || obsMatch[i] !== expMatch[i]) begin
          testsFailed++;
          $display("[TB] FAIL dir%0d_match bit %0d: got %b expected %b", v, i + 1,
                   (obsMatch.size() > i) ? obsMatch[i] : 1'bx, expMatch[i]);
        end
      end
      testsRun++;
      if (obsFetched != nb || obsStray != 0 || obsReadyShift != 0 || obsBusyLow != 0) begin
        testsFailed++;
        $display("[TB] FAIL dir%0d_protocol: fetched=%0d stray=%0d readyInShift=%0d busyLow=%0d expected %0d/0/0/0",
                 v, obsFetched, obsStray, obsReadyShift, obsBusyLow, nb);
      end
      testsRun++;
      if (obsIdleBusy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL dir%0d_idle: busy=%b expected 0", v, obsIdleBusy);
      end
    end
  endtask

  task automatic test_abort_and_recover();
    int exp;
    @(negedge clk);
    start_i = 1'b1; cfg_pat_i = 4'b1111; len_i = LEN_W'(16);
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 20 && !byte_ready_o; c++) @(negedge clk);
    byte_valid_i = 1'b1; byte_i = 8'hFF;
    @(negedge clk);
    byte_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    testsRun++;
    if (busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL abort_midframe_busy: got %b expected 1", busy_o);
    end
    #2 rst = 1'b0;
    #1;
    testsRun++;
    if (busy_o !== 1'b0 || byte_ready_o !== 1'b0 || match_o !== 1'b0 || done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_flags: busy=%b ready=%b match=%b done=%b expected 0",
               busy_o, byte_ready_o, match_o, done_o);
    end
    testsRun++;
    if (count_o !== '0) begin
      testsFailed++;
      $display("[TB] FAIL abort_count: got %0d expected 0", count_o);
    end
    @(negedge clk);
    rst = 1'b1;
    frameBytes = {8'hB6};
    exp = model_frame(4'b1011, 8);
    run_frame(4'b1011, 8, 0, 1'b1, 1'b0);
    testsRun++;
    if (obsTimeout || !obsDone || obsCount !== CNT_W'(2) || exp != 2) begin
      testsFailed++;
      $display("[TB] FAIL recover_count: done=%b got %0d model %0d expected 2",
               obsDone, obsCount, exp);
    end
  endtask

  // One 600-byte frame, then short random frames issued back to back.
  task automatic test_random_stream();
    logic [PAT_W-1:0] pat;
    int len, exp, nb;
    for (int f = 0; f < 12; f++) begin
      pat = PAT_W'($urandom);
      len = (f == 0) ? 600 * DATA_W : int'($urandom_range(40, 1));
      nb  = (len + DATA_W - 1) / DATA_W;
      frameBytes.delete();
      for (int i = 0; i < nb; i++) frameBytes.push_back(DATA_W'($urandom));
      exp = model_frame(pat, len);
      run_frame(pat, len, (f == 0) ? 2 : 3, 1'b0, f[0]);
      testsRun++;
      if (obsTimeout || obsEarlyDone || !obsDone || obsCount !== CNT_W'(exp)) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_count: timeout=%b early=%b done=%b got %0d expected %0d",
                 f, obsTimeout, obsEarlyDone, obsDone, obsCount, exp);
      end
      for (int i = 0; i < len; i++) begin
        testsRun++;
        if (obsMatch.size() <= i || obsMatch[i] !== expMatch[i]) begin
          testsFailed++;
          $display("[TB] FAIL rand%0d_match bit %0d: got %b expected %b", f, i + 1,
                   (obsMatch.size() > i) ? obsMatch[i] : 1'bx, expMatch[i]);
        end
      end
      testsRun++;
      if (obsFetched != nb || obsStray != 0 || obsReadyShift != 0 || obsIdleBusy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_protocol: fetched=%0d stray=%0d readyInShift=%0d idleBusy=%b expected %0d/0/0/0",
                 f, obsFetched, obsStray, obsReadyShift, obsIdleBusy, nb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort_and_recover();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
